// File: rtl/inst_sequencer.sv
// inst_sequencer: multi-cycle fetch/decode/exec/writeback control with PC, retire counter and fetch timeout
module inst_sequencer #(
  parameter int PC_W     = 32,
  parameter int RESET_PC = 0,
  parameter int TIMEOUT  = 15,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             halt_req,
  input  logic             imem_ack,
  input  logic [31:0]      imem_rdata,
  input  logic [6:0]       dec_opcode,
  input  logic             dec_reg_write,
  output logic             imem_req,
  output logic [PC_W-1:0]  imem_addr,
  output logic [31:0]      instr,
  output logic             alu_en,
  output logic             rf_we,
  output logic             busy,
  output logic             illegal,
  output logic             error,
  output logic [CNT_W-1:0] retired
);
  localparam int WW = $clog2(TIMEOUT + 1);
  typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, WB, ERROR} state_t;
  state_t            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [31:0]       instr_q, instr_d;
  logic [CNT_W-1:0]  ret_q, ret_d;
  logic              ill_q, ill_d;
  logic [WW-1:0]     wait_q, wait_d;
  logic              supported;
  assign supported = (dec_opcode == 7'b0110011) || (dec_opcode == 7'b0010011);
  assign imem_req  = state_q == FETCH;
  assign imem_addr = pc_q;
  assign instr     = instr_q;
  assign alu_en    = state_q == EXEC;
  assign rf_we     = (state_q == WB) && dec_reg_write && supported;
  assign busy      = (state_q != IDLE) && (state_q != ERROR);
  assign illegal   = ill_q;
  assign error     = state_q == ERROR;
  assign retired   = ret_q;
  // Next-state logic; ack wins over timeout in the final FETCH cycle
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    ret_d   = ret_q;
    ill_d   = ill_q;
    wait_d  = wait_q;
    case (state_q)
      IDLE:   if (start) begin
                state_d = FETCH;
                pc_d    = PC_W'(RESET_PC);
              end
      FETCH:  if (imem_ack) begin
                instr_d = imem_rdata;
                wait_d  = '0;
                state_d = DECODE;
              end else if (wait_q == WW'(TIMEOUT)) state_d = ERROR;
              else wait_d = wait_q + 1'b1;
      DECODE: state_d = EXEC;
      EXEC:   begin
                ill_d   = ill_q | ~supported;
                state_d = WB;
              end
      WB:     begin
                pc_d    = pc_q + PC_W'(4);
                ret_d   = ret_q + 1'b1;
                state_d = (halt_req || !start) ? IDLE : FETCH;
              end
      default: state_d = ERROR;
    endcase
  end
  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      pc_q    <= PC_W'(RESET_PC);
      instr_q <= 32'h0000_0013;
      ret_q   <= '0;
      ill_q   <= 1'b0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      ret_q   <= ret_d;
      ill_q   <= ill_d;
      wait_q  <= wait_d;
    end
  end
endmodule

// File: tb/tb_inst_sequencer.sv
// tb_inst_sequencer: random programs against a transaction-level model with a scoreboard monitor
module tb_inst_sequencer;
  localparam int PC_W = 4, RESET_PC = 12, TIMEOUT = 6, CNT_W = 4;
  logic clk = 0, reset = 1, start = 0, halt_req = 0, imem_ack = 0, dec_reg_write = 0;
  logic [31:0] imem_rdata = 0;
  logic [6:0] dec_opcode;
  logic imem_req, alu_en, rf_we, busy, illegal, error;
  logic [PC_W-1:0] imem_addr;
  logic [31:0] instr;
  logic [CNT_W-1:0] retired;
  always #5 clk = ~clk;
  assign dec_opcode = instr[6:0];
  inst_sequencer #(.PC_W(PC_W), .RESET_PC(RESET_PC), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) u_dut (
    .clk(clk), .reset(reset), .start(start), .halt_req(halt_req), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .dec_opcode(dec_opcode), .dec_reg_write(dec_reg_write),
    .imem_req(imem_req), .imem_addr(imem_addr), .instr(instr), .alu_en(alu_en), .rf_we(rf_we),
    .busy(busy), .illegal(illegal), .error(error), .retired(retired));
  typedef struct {logic err; logic [PC_W-1:0] pc; logic [PC_W-1:0] npc; logic [31:0] word;
                  logic we; logic ill; logic [CNT_W-1:0] ret; int fc;} exp_t;
  typedef struct {int dly; logic [31:0] word; logic we;} plan_t;
  exp_t exp_q[$];
  plan_t plan_q[$];
  exp_t e_mon;
  int errors = 0, checks = 0;
  logic [PC_W-1:0] m_pc;
  logic [CNT_W-1:0] m_ret = 0;
  logic m_ill = 0;
  task automatic chk(string name, logic [63:0] act, logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask
  task automatic cyc(int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask
  int fcnt = 0;
  always begin
    @(posedge clk); #2;
    if (reset) begin imem_ack = 0; fcnt = 0; end
    else if (imem_req && plan_q.size() > 0) begin
      if (fcnt == plan_q[0].dly) begin
        imem_ack = 1; imem_rdata = plan_q[0].word; dec_reg_write = plan_q[0].we;
        plan_q.delete(0); fcnt = 0;
      end else begin imem_ack = 0; fcnt++; end
    end else imem_ack = 0;
  end
  int fc = 0, ac = 0, wc = 0;
  logic [CNT_W-1:0] prev_ret;
  logic prev_err, sync = 1;
  always @(negedge clk) begin
    if (reset || sync) begin
      fc = 0; ac = 0; wc = 0; prev_ret = retired; prev_err = error; sync = reset;
    end else begin
      if (retired !== prev_ret) begin
        if (exp_q.size() == 0 || exp_q[0].err) begin
          checks++; errors++; $display("FAIL retire: unexpected retirement, retired=%0d", retired);
        end else begin
          e_mon = exp_q.pop_front();
          chk("pc_after", imem_addr, e_mon.npc);
          chk("retired", retired, e_mon.ret);
          chk("illegal", illegal, e_mon.ill);
          chk("instr_latched", instr, e_mon.word);
          chk("rf_we_pulses", wc, e_mon.we);
          chk("fetch_cycles", fc, e_mon.fc);
          chk("exec_cycles", ac, 1);
        end
        fc = 0; ac = 0; wc = 0; prev_ret = retired;
      end
      if (error && !prev_err) begin
        if (exp_q.size() == 0 || !exp_q[0].err) begin
          checks++; errors++; $display("FAIL error_entry: unexpected ERROR, pc=%0h", imem_addr);
        end else begin
          e_mon = exp_q.pop_front();
          chk("timeout_cycles", fc, e_mon.fc);
          chk("err_addr", imem_addr, e_mon.pc);
          chk("err_busy", busy, 0);
          chk("err_req", imem_req, 0);
        end
        fc = 0;
      end
      prev_err = error;
      if (imem_req) begin
        fc++;
        if (exp_q.size() > 0) chk("fetch_addr", imem_addr, exp_q[0].pc);
      end
      ac += int'(alu_en);
      wc += int'(rf_we);
    end
  end
  task automatic add_instr(int dly, logic [31:0] word, logic we, bit track);
    exp_t e;
    plan_t p;
    logic sup;
    sup = (word[6:0] == 7'h33) || (word[6:0] == 7'h13);
    p.dly = dly; p.word = word; p.we = we;
    plan_q.push_back(p);
    if (track) begin
      m_ill = m_ill | !sup;
      m_ret = m_ret + 1'b1;
      e.err = 0; e.pc = m_pc; e.npc = PC_W'((int'(m_pc) + 4) % (1 << PC_W));
      e.word = word; e.we = we & sup; e.ill = m_ill; e.ret = m_ret; e.fc = dly + 1;
      exp_q.push_back(e);
      m_pc = e.npc;
    end
  endtask
  task automatic wait_ret(logic [CNT_W-1:0] v);
    int k = 0;
    while (retired !== v && k < 300) begin cyc(1); k++; end
    if (retired !== v) begin
      checks++; errors++; $display("FAIL wait_retired: got %0d expected %0d", retired, v);
    end
  endtask
  task automatic go(int n, bit use_halt);
    logic [CNT_W-1:0] base;
    base = m_ret - CNT_W'(n);
    start = 1;
    wait_ret(base + CNT_W'(n - 1));
    if (use_halt || n == 1) halt_req = 1; else start = 0;
    wait_ret(base + CNT_W'(n));
    start = 0; halt_req = 0;
    cyc(2);
    chk("idle_busy", busy, 0);
    chk("idle_req", imem_req, 0);
  endtask
  task automatic do_reset;
    reset = 1; start = 0; halt_req = 0;
    plan_q.delete(); exp_q.delete();
    cyc(2);
    reset = 0; m_ret = 0; m_ill = 0;
  endtask
  function automatic logic [31:0] rand_word();
    logic [31:0] r, x;
    int s;
    r = $urandom(); x = $urandom(); s = $urandom_range(0, 3);
    return {r[31:7], s == 0 ? 7'h33 : s == 1 ? 7'h13 : s == 2 ? x[6:0] : 7'h63};
  endfunction
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    cyc(1);
    do_reset;
    chk("rst_req", imem_req, 0); chk("rst_busy", busy, 0); chk("rst_error", error, 0);
    chk("rst_illegal", illegal, 0); chk("rst_rf_we", rf_we, 0); chk("rst_alu_en", alu_en, 0);
    chk("rst_retired", retired, 0); chk("rst_pc", imem_addr, RESET_PC); chk("rst_instr", instr, 32'h13);
    m_pc = PC_W'(RESET_PC); add_instr(0, 32'h00500093, 1, 1); go(1, 1);
    m_pc = PC_W'(RESET_PC); add_instr(3, 32'h00a00113, 1, 1); go(1, 1);
    m_pc = PC_W'(RESET_PC); add_instr(0, 32'h00000063, 1, 1); go(1, 1);
    chk("illegal_sticky", illegal, 1);
    m_pc = PC_W'(RESET_PC); add_instr(1, 32'h002081b3, 1, 1); add_instr(0, 32'h00100093, 0, 1); go(2, 1);
    m_pc = PC_W'(RESET_PC); add_instr(TIMEOUT, 32'h00300093, 1, 1); go(1, 1);
    do_reset;
    repeat (14) begin
      int n, r;
      n = $urandom_range(1, 4);
      m_pc = PC_W'(RESET_PC);
      for (int i = 0; i < n; i++) begin
        r = $urandom_range(0, 9);
        add_instr(r == 9 ? TIMEOUT : r % 4, rand_word(), 1'($urandom_range(0, 1)), 1);
      end
      go(n, 1'($urandom_range(0, 1)));
    end
    begin
      exp_t e;
      plan_t p;
      int k = 0;
      p.dly = 999; p.word = 32'h13; p.we = 1;
      plan_q.push_back(p);
      e.err = 1; e.pc = PC_W'(RESET_PC); e.npc = 0; e.word = 0; e.we = 0; e.ill = 0; e.ret = 0;
      e.fc = TIMEOUT + 1;
      exp_q.push_back(e);
      start = 1;
      while (!error && k < 100) begin cyc(1); k++; end
      chk("error_reached", error, 1);
      repeat (6) begin
        start = ~start;
        cyc(1);
        chk("err_hold", error, 1); chk("err_hold_busy", busy, 0); chk("err_hold_req", imem_req, 0);
      end
    end
    do_reset;
    chk("post_err_reset", error, 0);
    begin
      int k = 0;
      bit saw_we = 0;
      add_instr(1, 32'h00500093, 1, 0);
      start = 1;
      while (!alu_en && k < 50) begin cyc(1); saw_we |= rf_we; k++; end
      chk("exec_reached", alu_en, 1);
      reset = 1; plan_q.delete();
      cyc(1);
      saw_we |= rf_we;
      chk("abort_busy", busy, 0); chk("abort_pc", imem_addr, RESET_PC); chk("abort_retired", retired, 0);
      chk("abort_alu_en", alu_en, 0); chk("abort_rf_we_seen", saw_we, 0);
      reset = 0; start = 0; m_ret = 0; m_ill = 0;
      cyc(2);
      chk("abort_idle", busy, 0);
    end
    m_pc = PC_W'(RESET_PC); add_instr(0, 32'h00500093, 1, 1); add_instr(2, 32'h00208033, 1, 1); go(2, 0);
    cyc(5);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
